// File: rtl/str_frame_gen_if.sv
// Byte link between the frame generator and the character classifier.
interface str_frame_gen_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/str_frame_gen.sv
// Framed string generator: \0, bracket, math symbol, digits, bracket, \0.
// Optional error injection produces malformed frames for the recognizer.
module str_frame_gen #(
    parameter int unsigned GAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        par1_sel,
    input  logic [1:0]        par2_sel,
    input  logic [2:0]        op_sel,
    input  logic [11:0]       digits,
    input  logic [1:0]        inject,
    str_frame_gen_if.master   link,
    output logic              busy,
    output logic              done,
    output logic [3:0]        byte_cnt
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SOF  = 4'd1;
    localparam logic [3:0] S_PAR1 = 4'd2;
    localparam logic [3:0] S_OP   = 4'd3;
    localparam logic [3:0] S_DIG  = 4'd4;
    localparam logic [3:0] S_PAR2 = 4'd5;
    localparam logic [3:0] S_EOF  = 4'd6;
    localparam logic [3:0] S_GAPW = 4'd7;
    localparam logic [3:0] S_FIN  = 4'd8;

    // Last value of the gap counter; unused when GAP is zero.
    localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    logic [3:0]  state_q, state_d;
    logic [3:0]  ret_q, ret_d;
    logic [3:0]  gap_q, gap_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  byte_cnt_q;

    logic [1:0]  par1_q, par2_q, inj_q;
    logic [2:0]  op_q;
    logic [11:0] digits_q;

    logic        byte_state;
    logic        accept;
    logic [1:0]  dig_last;
    logic [3:0]  follow;
    logic [3:0]  nib;
    logic [7:0]  data;

    // Decode whether the current state presents a byte on the link.
    always_comb begin
        byte_state = 1'b0;
        case (state_q)
            S_SOF, S_PAR1, S_OP, S_DIG, S_PAR2, S_EOF: byte_state = 1'b1;
            default:                                   byte_state = 1'b0;
        endcase
    end

    assign accept = byte_state & link.tx_ready;

    // Index of the final digit for the latched injection mode.
    always_comb begin
        case (inj_q)
            2'd1:    dig_last = 2'd0;
            2'd2:    dig_last = 2'd2;
            default: dig_last = 2'd1;
        endcase
    end

    // Byte state that follows the current one once its byte is accepted.
    always_comb begin
        follow = S_IDLE;
        case (state_q)
            S_SOF:  follow = S_PAR1;
            S_PAR1: follow = S_OP;
            S_OP:   follow = S_DIG;
            S_DIG: begin
                if (dig_q != dig_last) follow = S_DIG;
                else if (inj_q == 2'd3) follow = S_EOF;
                else follow = S_PAR2;
            end
            S_PAR2: follow = S_EOF;
            S_EOF:  follow = S_FIN;
            default: follow = S_IDLE;
        endcase
    end

    // Select the digit nibble for the current position and map it to ASCII.
    always_comb begin
        case (dig_q)
            2'd0:    nib = digits_q[3:0];
            2'd1:    nib = digits_q[7:4];
            default: nib = digits_q[11:8];
        endcase
    end

    // Byte presented on the link; zero whenever no byte is offered.
    always_comb begin
        data = 8'h00;
        case (state_q)
            S_PAR1, S_PAR2: begin
                case ((state_q == S_PAR1) ? par1_q : par2_q)
                    2'd0:    data = 8'h28;
                    2'd1:    data = 8'h29;
                    2'd2:    data = 8'h5B;
                    default: data = 8'h5D;
                endcase
            end
            S_OP: begin
                case (op_q)
                    3'd0:    data = 8'h2B;
                    3'd1:    data = 8'h2D;
                    3'd2:    data = 8'h2A;
                    3'd3:    data = 8'h2F;
                    3'd4:    data = 8'h5C;
                    3'd5:    data = 8'h3D;
                    3'd6:    data = 8'h3C;
                    default: data = 8'h3E;
                endcase
            end
            S_DIG:   data = (nib > 4'd9) ? 8'h39 : {4'h3, nib};
            default: data = 8'h00;
        endcase
    end

    assign link.tx_data  = data;
    assign link.tx_valid = byte_state;
    assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done          = (state_q == S_FIN);
    assign byte_cnt      = byte_cnt_q;

    // Next-state logic: sequence bytes, optionally detouring through the gap wait.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        gap_d   = gap_q;
        dig_d   = dig_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SOF;
            end
            S_GAPW: begin
                if (gap_q == GAP_LAST) state_d = ret_q;
                else gap_d = gap_q + 4'd1;
            end
            S_FIN: state_d = S_IDLE;
            S_SOF, S_PAR1, S_OP, S_DIG, S_PAR2, S_EOF: begin
                if (accept) begin
                    if (state_q == S_OP) dig_d = 2'd0;
                    else if (state_q == S_DIG) dig_d = dig_q + 2'd1;
                    // The last byte goes straight to FIN without a gap.
                    if (GAP == 0 || follow == S_FIN) begin
                        state_d = follow;
                    end else begin
                        state_d = S_GAPW;
                        ret_d   = follow;
                        gap_d   = 4'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, gap and digit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            gap_q   <= 4'd0;
            dig_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            gap_q   <= gap_d;
            dig_q   <= dig_d;
        end
    end

    // Frame configuration is captured only when a frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par1_q   <= 2'd0;
            par2_q   <= 2'd0;
            op_q     <= 3'd0;
            digits_q <= 12'd0;
            inj_q    <= 2'd0;
        end else if (state_q == S_IDLE && start) begin
            par1_q   <= par1_sel;
            par2_q   <= par2_sel;
            op_q     <= op_sel;
            digits_q <= digits;
            inj_q    <= inject;
        end
    end

    // Accepted-byte count: cleared on start, saturates at 15, held after the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 4'd0;
        end else if (state_q == S_IDLE && start) begin
            byte_cnt_q <= 4'd0;
        end else if (accept && byte_cnt_q != 4'd15) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_str_frame_gen.sv
// Self-checking bench for str_frame_gen: scoreboard of expected bytes per DUT.
module tb_str_frame_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  par1_sel = 2'd0;
    logic [1:0]  par2_sel = 2'd0;
    logic [2:0]  op_sel = 3'd0;
    logic [11:0] digits = 12'd0;
    logic [1:0]  inject = 2'd0;
    logic        busy0, done0, busy1, done1;
    logic [3:0]  bc0, bc1;

    str_frame_gen_if link0 ();
    str_frame_gen_if link1 ();

    str_frame_gen #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .par1_sel(par1_sel), .par2_sel(par2_sel),
        .op_sel(op_sel), .digits(digits), .inject(inject), .link(link0),
        .busy(busy0), .done(done0), .byte_cnt(bc0)
    );

    str_frame_gen #(.GAP(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .par1_sel(par1_sel), .par2_sel(par2_sel),
        .op_sel(op_sel), .digits(digits), .inject(inject), .link(link1),
        .busy(busy1), .done(done1), .byte_cnt(bc1)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int cyc = 0, acc0 = 0, done_cnt0 = 0, last_acc0 = 0, last_acc1 = 0, idle1 = 0;
    bit in_frame1 = 1'b0;
    bit stall0 = 1'b0;
    logic [7:0] stall_data0, e0, e1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] par_chr(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h28;
            2'd1:    return 8'h29;
            2'd2:    return 8'h5B;
            default: return 8'h5D;
        endcase
    endfunction

    function automatic logic [7:0] op_chr(input logic [2:0] s);
        logic [7:0] tbl [8] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E};
        return tbl[s];
    endfunction

    function automatic logic [7:0] dig_chr(input logic [3:0] n);
        return (n > 4'd9) ? 8'h39 : {4'h3, n};
    endfunction

    task automatic set_cfg(input logic [1:0] p1, input logic [1:0] p2, input logic [2:0] op,
                           input logic [11:0] dg, input logic [1:0] inj);
        par1_sel = p1;
        par2_sel = p2;
        op_sel   = op;
        digits   = dg;
        inject   = inj;
    endtask

    // Build the expected frame from the current configuration.
    task automatic push_frame(input bit which);
        logic [7:0] b[$];
        int n;
        n = (inject == 2'd1) ? 1 : (inject == 2'd2) ? 3 : 2;
        b.push_back(8'h00);
        b.push_back(par_chr(par1_sel));
        b.push_back(op_chr(op_sel));
        for (int i = 0; i < n; i++) b.push_back(dig_chr(digits[i*4 +: 4]));
        if (inject != 2'd3) b.push_back(par_chr(par2_sel));
        b.push_back(8'h00);
        foreach (b[i]) begin
            if (which) q1.push_back(b[i]);
            else q0.push_back(b[i]);
        end
    endtask

    task automatic pulse(input bit which);
        @(posedge clk);
        #1;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        if (which) start1 = 1'b0; else start0 = 1'b0;
    endtask

    // Wait for done with a cycle budget, optionally toggling tx_ready every cycle.
    task automatic run(input bit which, input int budget, input bit tog);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if ((which ? done1 : done0) === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (tog) link0.tx_ready = ~link0.tx_ready;
            end
        end
        check(which ? "done1_seen" : "done0_seen", 32'(got), 32'd1);
    endtask

    // Monitors: pop the scoreboard on every accepted byte and check link timing.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall0    = 1'b0;
            in_frame1 = 1'b0;
            idle1     = 0;
        end else begin
            if (stall0) begin
                check("stall_valid0", 32'(link0.tx_valid), 32'd1);
                check("stall_data0", 32'(link0.tx_data), 32'(stall_data0));
            end
            stall0      = link0.tx_valid && !link0.tx_ready;
            stall_data0 = link0.tx_data;
            if (link0.tx_valid && link0.tx_ready) begin
                e0 = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
                check("byte0", 32'(link0.tx_data), 32'(e0));
                acc0++;
                last_acc0 = cyc;
            end
            if (done0) begin
                done_cnt0++;
                check("done_latency0", 32'(cyc - last_acc0), 32'd1);
            end
            if (link1.tx_valid && link1.tx_ready) begin
                e1 = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
                check("byte1", 32'(link1.tx_data), 32'(e1));
                if (in_frame1) check("gap_len1", 32'(idle1), 32'd3);
                in_frame1 = 1'b1;
                idle1     = 0;
                last_acc1 = cyc;
            end else if (busy1 && !link1.tx_valid) begin
                idle1++;
            end
            if (done1) begin
                check("done_latency1", 32'(cyc - last_acc1), 32'd1);
                in_frame1 = 1'b0;
            end
        end
    end

    initial begin
        int base, d, budget;
        int len_tbl [4] = '{7, 6, 8, 6};
        link0.tx_ready = 1'b1;
        link1.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid0", 32'(link0.tx_valid), 32'd0);
        check("rst_data0", 32'(link0.tx_data), 32'h00);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_cnt0", 32'(bc0), 32'd0);
        check("rst_valid1", 32'(link1.tx_valid), 32'd0);

        // Valid frame, back-to-back bytes
        set_cfg(2'd0, 2'd1, 3'd0, 12'h042, 2'd0);
        push_frame(1'b0);
        pulse(1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("b2b_valid0", 32'(link0.tx_valid), 32'd1);
        end
        @(negedge clk);
        check("fin_done0", 32'(done0), 32'd1);
        check("fin_busy0", 32'(busy0), 32'd0);
        check("fin_valid0", 32'(link0.tx_valid), 32'd0);
        check("fin_cnt0", 32'(bc0), 32'd7);
        check("q0_empty_a", 32'(q0.size()), 32'd0);
        @(negedge clk);
        check("done_pulse0", 32'(done0), 32'd0);
        check("cnt_hold0", 32'(bc0), 32'd7);

        // Same frame with tx_ready toggling
        push_frame(1'b0);
        pulse(1'b0);
        run(1'b0, 60, 1'b1);
        link0.tx_ready = 1'b1;
        check("toggle_cnt0", 32'(bc0), 32'd7);
        check("q0_empty_b", 32'(q0.size()), 32'd0);

        // GAP=3 instance
        set_cfg(2'd2, 2'd3, 3'd5, 12'h987, 2'd0);
        push_frame(1'b1);
        pulse(1'b1);
        run(1'b1, 200, 1'b0);
        check("gap_cnt1", 32'(bc1), 32'd7);
        check("q1_empty", 32'(q1.size()), 32'd0);

        // Error-injection frames
        for (int inj = 1; inj < 4; inj++) begin
            set_cfg(2'd0, 2'd1, 3'd7, 12'h5A9, 2'(inj));
            push_frame(1'b0);
            pulse(1'b0);
            run(1'b0, 40, 1'b0);
            check("inj_cnt0", 32'(bc0), 32'(len_tbl[inj]));
            check("q0_empty_inj", 32'(q0.size()), 32'd0);
        end

        // Reset after the third accepted byte
        set_cfg(2'd3, 2'd2, 3'd2, 12'h321, 2'd0);
        push_frame(1'b0);
        base = acc0;
        pulse(1'b0);
        budget = 0;
        while (acc0 - base < 3 && budget < 40) begin
            @(posedge clk);
            budget++;
        end
        check("three_accepted", 32'(acc0 - base), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(link0.tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        check("mid_rst_cnt", 32'(bc0), 32'd0);
        check("mid_rst_data", 32'(link0.tx_data), 32'h00);
        q0.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_resume_valid", 32'(link0.tx_valid), 32'd0);
        check("no_resume_busy", 32'(busy0), 32'd0);
        set_cfg(2'd1, 2'd0, 3'd4, 12'h210, 2'd0);
        push_frame(1'b0);
        pulse(1'b0);
        run(1'b0, 40, 1'b0);
        check("post_rst_cnt", 32'(bc0), 32'd7);
        check("q0_empty_c", 32'(q0.size()), 32'd0);

        // start held high through the frame and the FIN cycle
        set_cfg(2'd1, 2'd0, 3'd3, 12'h000, 2'd0);
        push_frame(1'b0);
        @(negedge clk);
        #1;
        d = done_cnt0;
        @(posedge clk);
        #1 start0 = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (done0 !== 1'b1 && budget < 40);
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("single_done", 32'(done_cnt0 - d), 32'd1);
        check("idle_busy", 32'(busy0), 32'd0);
        check("q0_empty_d", 32'(q0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/str_frame_gen.md
Name: str_frame_gen

Overview:
- Transmit-side counterpart of the string-recognizer FSM.
- Generates a framed byte string that the recognizer grammar accepts: \0, bracket, math symbol, exactly two digits, bracket, \0.
- Optional error injection produces malformed frames to exercise the recognizer's ERROR/error_verify path.
- Sits in the test/stimulus path, feeding the byte link (valid/ready) that drives the character classifier and recognizer.

Parameters:
- GAP, default 0: idle cycles with tx_valid low inserted after each accepted byte, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request, sampled only in IDLE.
- par1_sel  in  2  opening bracket: 0 '(' 0x28, 1 ')' 0x29, 2 '[' 0x5B, 3 ']' 0x5D.
- par2_sel  in  2  closing bracket, same encoding as par1_sel.
- op_sel  in  3  math symbol: 0 '+' 0x2B, 1 '-' 0x2D, 2 '*' 0x2A, 3 '/' 0x2F, 4 '\' 0x5C, 5 '=' 0x3D, 6 '<' 0x3C, 7 '>' 0x3E.
- digits  in  12  three BCD nibbles, [3:0] sent first; nibble >9 is transmitted as '9' (0x39).
- inject  in  2  0 valid frame; 1 one digit only; 2 three digits; 3 closing bracket omitted.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a rising edge.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the final \0 is accepted.
- byte_cnt  out  4  number of bytes accepted in the current frame.

Behaviour:
- Reset (async, any time, including mid-frame): FSM to IDLE; tx_data=0x00, tx_valid=0, busy=0, done=0, byte_cnt=0; gap counter=0; latched configuration cleared. Any partial frame is abandoned; nothing resumes after reset release.
- States: IDLE, SOF, PAR1, OP, DIG, PAR2, EOF, GAPW, FIN.
- IDLE:
  - start=1 at an edge latches par1_sel, par2_sel, op_sel, digits and inject.
  - Next state SOF; busy=1 from the following cycle.
  - start while busy is ignored. Inputs are not re-sampled mid-frame.
- Byte states (SOF, PAR1, OP, DIG, PAR2, EOF):
  - tx_valid=1 and tx_data is held stable until acceptance.
  - tx_ready may be low indefinitely; the stall has no timeout.
- On acceptance: byte_cnt increments, saturating at 15.
  - GAP=0: next byte presented the following cycle, tx_valid stays high.
  - GAP>0: enter GAPW with tx_valid=0 for exactly GAP cycles, then present the next byte.
  - EOF acceptance goes straight to FIN; no gap is inserted after the last byte.
- Sequence:
  - SOF sends 0x00, then PAR1, then OP.
  - DIG sends digit index 0..N-1 using an internal 2-bit counter, cleared on entering DIG. N=2 for inject 0 and 3, N=1 for inject 1, N=3 for inject 2.
  - After the digits: PAR2, except inject=3, which skips PAR2 and goes directly to EOF.
  - EOF sends 0x00.
- FIN lasts 1 cycle: done=1, busy=0, tx_valid=0; then IDLE. byte_cnt holds its value until the next start, then clears.
- Frame lengths: inject 0 = 7 bytes; inject 1 = 6; inject 2 = 8; inject 3 = 6.
- Minimum latency with GAP=0 and tx_ready tied high: first byte valid 1 cycle after start; done 1 cycle after the final byte is accepted.
- A start that coincides with the FIN cycle is ignored. start is accepted only in IDLE.
- Frames with inject 0 must be accepted by the recognizer (reaches STOP). Frames with inject 1, 2 or 3 must drive the recognizer to ERROR.

Test Plan:
- GAP=0, tx_ready=1, start with par1=0, op=0, digits=0x042, par2=1, inject=0 -> bytes 00 28 2B 32 34 29 00 on 7 consecutive cycles; done 1 cycle later; byte_cnt=7; recognizer reaches STOP.
- Same configuration, tx_ready toggling 1/0 each cycle -> identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; byte_cnt=7.
- GAP=3, inject=0 -> 3 cycles of tx_valid=0 between bytes; no gap after the final 00; total of 7 accepted bytes.
- inject=1/2/3 with op=7, digits=0x5A9 -> 1: 00 28 3E 39 29 00 / 2: 00 28 3E 39 39 35 29 00 / 3: 00 28 3E 39 39 00 (nibble 0xA sent as 0x39) -> recognizer enters ERROR each time.
- rst asserted after the 3rd byte is accepted -> tx_valid, busy, done and byte_cnt all 0 immediately; a new start after release sends a full frame from 00.
- start pulsed while busy and during the FIN cycle -> ignored; exactly one frame is sent and done pulses once.
